rx: RTL and testbench
=====================

RX -- requirements
Module: rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, meaning clk cycles per UART bit; legal values are even and >= 4.
REQ-002 SHALL have port clk  input  1  system clock; all logic runs on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port din  input  1  asynchronous serial line; idle high; 8N1, LSB first.
REQ-005 SHALL have port data  output  8  last correctly framed received byte.
REQ-006 SHALL have port valid  output  1  one-cycle pulse: data has just been updated.
REQ-007 SHALL have port frame_err  output  1  one-cycle pulse: stop bit was sampled low.
REQ-008 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-009 SHALL pass din through a 2-flop synchronizer, with both flops reset to 1; din_s is the second flop output, and all decisions use din_s only.
REQ-010 SHALL implement states IDLE, START, DATA, STOP, WAIT_IDLE, with a bit-timer counter of width clog2(CLKS_PER_BIT) and a 3-bit bit index.
REQ-011 IDLE: on the first cycle with din_s==0, SHALL go to START and clear the timer; otherwise SHALL remain in IDLE.
REQ-012 START: SHALL sample din_s when the timer reaches CLKS_PER_BIT/2-1 (mid start bit).
- If din_s==0: SHALL go to DATA, clear timer and bit index.
- If din_s==1 (glitch): SHALL return to IDLE with no valid and no frame_err.
REQ-013 DATA: SHALL sample din_s when the timer reaches CLKS_PER_BIT-1.
- The sample SHALL be shifted into a shift register, LSB first (bit index 0 = first data bit).
- The timer SHALL clear on each sample.
- After index 7 is sampled, SHALL go to STOP.
REQ-014 STOP: SHALL sample din_s when the timer reaches CLKS_PER_BIT-1.
- If 1: on the next clock SHALL load data with the shift register, pulse valid for exactly 1 cycle, and go to IDLE.
- If 0: on the next clock SHALL pulse frame_err for exactly 1 cycle, leave data unchanged, and go to WAIT_IDLE.
REQ-015 WAIT_IDLE: SHALL remain in WAIT_IDLE until din_s==1, then go to IDLE; a line held low (break) SHALL produce exactly one frame_err and no further events.
REQ-016 valid and frame_err SHALL never be high in the same cycle.
REQ-017 From IDLE, a start bit beginning immediately after the stop-bit sample cycle SHALL be received without loss (back-to-back frames).
REQ-018 Timing: each bit SHALL be sampled at its nominal centre ± 1 cycle, relative to the first din_s low cycle; valid SHALL rise 3 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after din falls, within ±1 cycle.
REQ-019 busy SHALL be a registered decode of state != IDLE.
REQ-020 din changes during a bit period other than at the sample point SHALL not affect the received value.

Reset
REQ-021 With rst high at a rising edge, the block SHALL set:
- state IDLE
- timer 0, bit index 0, shift register 0x00
- data 0x00
- valid 0, frame_err 0, busy 0
- synchronizer flops 1
REQ-022 rst asserted mid-frame SHALL abort the frame with no valid or frame_err pulse; after rst is released with din high, the next full frame SHALL be received correctly.

Verification
REQ-023 CLKS_PER_BIT=16; drive frame 0x6C (start, bits 0,0,1,1,0,1,1,0, stop) at 16 clk/bit -> exactly one valid pulse, data=0x6C, frame_err never high.
REQ-024 Drive back-to-back frames 0x00 then 0xFF with no idle gap -> two valid pulses 160 cycles apart, data=0x00 then 0xFF.
REQ-025 Drive din low for 4 cycles, then high -> busy pulses briefly, returns to IDLE, no valid, no frame_err.
REQ-026 Drive frame 0xA5 with stop bit low, hold din low 100 cycles, release, then send 0x3C -> frame_err pulses once, data stays at its prior value, then a valid pulse with data=0x3C.
REQ-027 Assert rst for 1 cycle during data bit 4 of 0x55, then send 0x81 -> no event for 0x55, then a valid pulse with data=0x81.
REQ-028 Drive frame 0x6C with the clock ±3% off the nominal bit period -> data=0x6C, valid pulses once.

Source files
------------

// File: rtl/rx.sv
`timescale 1ns/100ps
// ---------------------------------------------------------------------------
// rx : 8N1 UART receiver, LSB first, oversampled by CLKS_PER_BIT.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   din        in   asynchronous serial line, idle high
//   data[7:0]  out  last correctly framed byte
//   valid      out  one-cycle pulse when data has just been updated
//   frame_err  out  one-cycle pulse when the stop bit was sampled low
//   busy       out  high whenever the receiver is not idle
//
// The line is double-flopped; every decision uses the second flop (din_s).
// The start bit is confirmed at its middle, and every later bit is sampled
// one full bit period after the previous sample, so all samples sit near
// bit centres.
// ---------------------------------------------------------------------------
module rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t          state_r;
  logic [TW-1:0]   timer_r;
  logic [2:0]      idx_r;
  logic [7:0]      shift_r;
  logic            sync_r;
  logic            din_s;

  // Two-flop synchronizer; both flops reset to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= 1'b1;
      din_s  <= 1'b1;
    end else begin
      sync_r <= din;
      din_s  <= sync_r;
    end
  end

  // Receive FSM with bit timer, bit index, shift register and registered outputs.
  // busy is updated together with every state change so it always equals
  // (state != IDLE).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      timer_r   <= '0;
      idx_r     <= 3'd0;
      shift_r   <= 8'h00;
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state_r)
        IDLE: begin
          if (!din_s) begin
            state_r <= START;
            timer_r <= '0;
            busy    <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        START: begin
          if (timer_r == HALF_M1) begin
            timer_r <= '0;
            if (!din_s) begin
              state_r <= DATA;
              idx_r   <= 3'd0;
            end else begin
              // Start bit did not survive to mid-bit: treat as a glitch.
              state_r <= IDLE;
              busy    <= 1'b0;
            end
          end else begin
            timer_r <= timer_r + 1'b1;
          end
        end
        DATA: begin
          if (timer_r == FULL_M1) begin
            timer_r <= '0;
            shift_r <= {din_s, shift_r[7:1]};
            idx_r   <= idx_r + 3'd1;
            if (idx_r == 3'd7) begin
              state_r <= STOP;
            end else begin
              state_r <= DATA;
            end
          end else begin
            timer_r <= timer_r + 1'b1;
          end
        end
        STOP: begin
          if (timer_r == FULL_M1) begin
            timer_r <= '0;
            if (din_s) begin
              data    <= shift_r;
              valid   <= 1'b1;
              state_r <= IDLE;
              busy    <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state_r   <= WAIT_IDLE;
            end
          end else begin
            timer_r <= timer_r + 1'b1;
          end
        end
        WAIT_IDLE: begin
          // A held-low line (break) stays here silently until it releases.
          if (din_s) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end else begin
            state_r <= WAIT_IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          timer_r <= '0;
          idx_r   <= 3'd0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx.sv
`timescale 1ns/100ps
module tb_rx;

  localparam int CPB = 16;
  localparam realtime BIT_NS = 160.0;

  logic       clk;
  logic       rst;
  logic       din;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Event monitor, sampled on the falling edge.
  int cyc = 0;
  int valid_cnt = 0;
  int ferr_cnt = 0;
  int busy_cnt = 0;
  int both_cnt = 0;
  int wide_cnt = 0;
  int last_valid_cyc = 0;
  int prev_valid_cyc = 0;
  logic [7:0] first_data;
  logic [7:0] last_data;
  logic prev_valid = 1'b0;
  logic prev_ferr = 1'b0;
  int fall_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      valid_cnt++;
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cyc;
      if (valid_cnt == 1) first_data = data;
      last_data = data;
    end
    if (frame_err) ferr_cnt++;
    if (busy) busy_cnt++;
    if (valid && frame_err) both_cnt++;
    if ((valid && prev_valid) || (frame_err && prev_ferr)) wide_cnt++;
    prev_valid = valid;
    prev_ferr  = frame_err;
  end

  // Drive one 8N1 frame; leaves din at the stop-bit level.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input realtime bit_t, input bit align);
    if (align) begin
      @(posedge clk);
      #1;
    end
    fall_cyc = cyc;
    din = 1'b0;
    #(bit_t);
    for (int i = 0; i < 8; i++) begin
      din = b[i];
      #(bit_t);
    end
    din = stop_bit;
    #(bit_t);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    din = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected %h", data, 8'h00); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_basic();
    int v0, f0, b0;
    v0 = valid_cnt; f0 = ferr_cnt; b0 = busy_cnt;
    send_frame(8'h6C, 1'b1, BIT_NS, 1'b1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    n_checks++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL basic_valid_count: got %0d expected 1", valid_cnt - v0); end
    n_checks++; if (data !== 8'h6C) begin n_fail++; $display("FAIL basic_data: got %h expected 6c", data); end
    n_checks++; if (ferr_cnt - f0 !== 0) begin n_fail++; $display("FAIL basic_ferr: got %0d expected 0", ferr_cnt - f0); end
    n_checks++; if ((last_valid_cyc - fall_cyc < 154) || (last_valid_cyc - fall_cyc > 156)) begin n_fail++; $display("FAIL basic_latency: got %0d expected 155 +/-1", last_valid_cyc - fall_cyc); end
    n_checks++; if (busy_cnt - b0 !== 152) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 152", busy_cnt - b0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = valid_cnt;
    send_frame(8'h00, 1'b1, BIT_NS, 1'b1);
    send_frame(8'hFF, 1'b1, BIT_NS, 1'b0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    n_checks++; if (valid_cnt - v0 !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d expected 2", valid_cnt - v0); end
    n_checks++; if (last_valid_cyc - prev_valid_cyc !== 160) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected 160", last_valid_cyc - prev_valid_cyc); end
    n_checks++; if (last_data !== 8'hFF) begin n_fail++; $display("FAIL b2b_second: got %h expected ff", last_data); end
    n_checks++; if (first_data !== 8'h6C && v0 == 0) begin n_fail++; $display("FAIL b2b_history: got %h expected 6c", first_data); end
  endtask

  task automatic test_glitch();
    int v0, f0, b0;
    logic [7:0] d0;
    v0 = valid_cnt; f0 = ferr_cnt; b0 = busy_cnt; d0 = 8'hFF;
    @(posedge clk);
    #1;
    din = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    din = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    n_checks++; if ((busy_cnt - b0 < 1) || (busy_cnt - b0 > 10)) begin n_fail++; $display("FAIL glitch_busy_pulse: got %0d cycles expected 1..10", busy_cnt - b0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_end: got %b expected 0", busy); end
    n_checks++; if (valid_cnt - v0 !== 0) begin n_fail++; $display("FAIL glitch_valid: got %0d expected 0", valid_cnt - v0); end
    n_checks++; if (ferr_cnt - f0 !== 0) begin n_fail++; $display("FAIL glitch_ferr: got %0d expected 0", ferr_cnt - f0); end
    n_checks++; if (data !== d0) begin n_fail++; $display("FAIL glitch_data: got %h expected %h", data, d0); end
  endtask

  task automatic test_frame_err();
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'hA5, 1'b0, BIT_NS, 1'b1);
    repeat (100) @(posedge clk);
    @(negedge clk);
    n_checks++; if (ferr_cnt - f0 !== 1) begin n_fail++; $display("FAIL ferr_count: got %0d expected 1", ferr_cnt - f0); end
    n_checks++; if (valid_cnt - v0 !== 0) begin n_fail++; $display("FAIL ferr_no_valid: got %0d expected 0", valid_cnt - v0); end
    n_checks++; if (data !== 8'hFF) begin n_fail++; $display("FAIL ferr_data_kept: got %h expected ff", data); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ferr_busy_break: got %b expected 1", busy); end
    din = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ferr_busy_release: got %b expected 0", busy); end
    send_frame(8'h3C, 1'b1, BIT_NS, 1'b1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    n_checks++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL ferr_recover_count: got %0d expected 1", valid_cnt - v0); end
    n_checks++; if (data !== 8'h3C) begin n_fail++; $display("FAIL ferr_recover_data: got %h expected 3c", data); end
    n_checks++; if (ferr_cnt - f0 !== 1) begin n_fail++; $display("FAIL ferr_single: got %0d expected 1", ferr_cnt - f0); end
  endtask

  task automatic test_rst_midframe();
    int v0, f0;
    logic [7:0] b;
    v0 = valid_cnt; f0 = ferr_cnt;
    b = 8'h55;
    @(posedge clk);
    #1;
    din = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      din = b[i];
      #(BIT_NS);
    end
    din = b[4];
    #(BIT_NS / 2.0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    din = 1'b1;
    repeat (12 * CPB) @(posedge clk);
    @(negedge clk);
    n_checks++; if (valid_cnt - v0 !== 0) begin n_fail++; $display("FAIL rstmid_valid: got %0d expected 0", valid_cnt - v0); end
    n_checks++; if (ferr_cnt - f0 !== 0) begin n_fail++; $display("FAIL rstmid_ferr: got %0d expected 0", ferr_cnt - f0); end
    n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL rstmid_data_cleared: got %h expected 00", data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    send_frame(8'h81, 1'b1, BIT_NS, 1'b1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    n_checks++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL rstmid_recover_count: got %0d expected 1", valid_cnt - v0); end
    n_checks++; if (data !== 8'h81) begin n_fail++; $display("FAIL rstmid_recover_data: got %h expected 81", data); end
  endtask

  task automatic test_baud_skew();
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h6C, 1'b1, BIT_NS * 1.03, 1'b1);
    repeat (30) @(posedge clk);
    @(negedge clk);
    n_checks++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL slow_count: got %0d expected 1", valid_cnt - v0); end
    n_checks++; if (data !== 8'h6C) begin n_fail++; $display("FAIL slow_data: got %h expected 6c", data); end
    send_frame(8'h6C, 1'b1, BIT_NS * 0.97, 1'b1);
    repeat (30) @(posedge clk);
    @(negedge clk);
    n_checks++; if (valid_cnt - v0 !== 2) begin n_fail++; $display("FAIL fast_count: got %0d expected 2", valid_cnt - v0); end
    n_checks++; if (data !== 8'h6C) begin n_fail++; $display("FAIL fast_data: got %h expected 6c", data); end
    n_checks++; if (ferr_cnt - f0 !== 0) begin n_fail++; $display("FAIL skew_ferr: got %0d expected 0", ferr_cnt - f0); end
  endtask

  initial begin
    rst = 1'b1;
    din = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_rst_midframe();
    test_baud_skew();
    @(negedge clk);
    n_checks++; if (both_cnt !== 0) begin n_fail++; $display("FAIL valid_and_ferr_together: got %0d expected 0", both_cnt); end
    n_checks++; if (wide_cnt !== 0) begin n_fail++; $display("FAIL pulse_width: got %0d wide pulses expected 0", wide_cnt); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
